// File: rtl/cms_axis_trace_receiver_if.sv
// rtl/cms_axis_trace_receiver_if.sv - wide trace-beat input stream and narrow serialized output stream
interface cms_axis_trace_receiver_if #(
  parameter int AXI_DATA_WIDTH = 1024,
  parameter int OUT_WIDTH      = 64
);
  localparam int WORDS = AXI_DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                      S_AXIS_tvalid;
  logic                      S_AXIS_tready;
  logic [AXI_DATA_WIDTH-1:0] S_AXIS_tdata;
  logic                      S_AXIS_tlast;

  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_WIDTH-1:0]      out_data;
  logic                      out_last;
  logic [IDX_W-1:0]          out_word_idx;

  modport slave (
    input  S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
    output S_AXIS_tready, out_valid, out_data, out_last, out_word_idx
  );

  modport master (
    output S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, out_ready,
    input  S_AXIS_tready, out_valid, out_data, out_last, out_word_idx
  );
endinterface

// File: rtl/cms_axis_trace_receiver.sv
// rtl/cms_axis_trace_receiver.sv - terminates the wide trace stream, serializes beats LSB-first,
// decodes PC/instruction, counts beats/frames and checks the tlast interval.
module cms_axis_trace_receiver #(
  parameter int AXI_DATA_WIDTH = 1024,
  parameter int OUT_WIDTH      = 64,
  parameter int XLEN           = 64,
  parameter int PC_LOCATION    = 805,
  parameter int INSTR_LOCATION = 933
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cms_axis_trace_receiver_if.slave bus,
  input  logic [31:0]              tlast_interval,
  input  logic                     err_clear,
  output logic [XLEN-1:0]          pkt_pc,
  output logic [31:0]              pkt_instr,
  output logic [31:0]              beat_count,
  output logic [31:0]              frame_count,
  output logic                     interval_error
);
  localparam int WORDS = AXI_DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          state_q, state_d;
  logic [WORDS-1:0][OUT_WIDTH-1:0] buf_q;
  logic                            buf_last_q;
  logic [IDX_W-1:0]                idx_q;
  logic [31:0]                     frame_beats_q;
  logic [31:0]                     frame_beats_inc;
  logic                            last_hs;
  logic                            tready;
  logic                            accept;
  logic                            err_set;

  // The final word's handshake frees the buffer, so a new beat may land on the same edge.
  assign last_hs = (state_q == SHIFT) && bus.out_ready && (idx_q == LAST_IDX);
  assign tready  = (state_q == IDLE) || last_hs;
  assign accept  = bus.S_AXIS_tvalid && tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_hs && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.S_AXIS_tready = tready;
    bus.out_valid     = (state_q == SHIFT);
    bus.out_data      = '0;
    bus.out_last      = 1'b0;
    bus.out_word_idx  = idx_q;
    if (state_q == SHIFT) begin
      bus.out_data = buf_q[idx_q];
      bus.out_last = buf_last_q && (idx_q == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      idx_q      <= '0;
    end else if (accept) begin
      buf_q      <= bus.S_AXIS_tdata;
      buf_last_q <= bus.S_AXIS_tlast;
      idx_q      <= '0;
    end else if ((state_q == SHIFT) && bus.out_ready) begin
      idx_q <= last_hs ? '0 : idx_q + 1'b1;
    end
  end

  assign frame_beats_inc = frame_beats_q + 32'd1;

  // A frame must close exactly on its tlast_interval-th beat; early or missing tlast both flag.
  always_comb begin
    err_set = 1'b0;
    if (accept && (tlast_interval != 32'd0)) begin
      if (bus.S_AXIS_tlast) begin
        err_set = (frame_beats_inc != tlast_interval);
      end else begin
        err_set = (frame_beats_inc == tlast_interval);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_pc         <= '0;
      pkt_instr      <= '0;
      beat_count     <= '0;
      frame_count    <= '0;
      frame_beats_q  <= '0;
      interval_error <= 1'b0;
    end else begin
      if (accept) begin
        pkt_pc     <= bus.S_AXIS_tdata[PC_LOCATION +: XLEN];
        pkt_instr  <= bus.S_AXIS_tdata[INSTR_LOCATION +: 32];
        beat_count <= beat_count + 32'd1;
        if (bus.S_AXIS_tlast) begin
          frame_count <= frame_count + 32'd1;
        end
        if (bus.S_AXIS_tlast || err_set) begin
          frame_beats_q <= '0;
        end else begin
          frame_beats_q <= frame_beats_inc;
        end
      end
      if (err_set) begin
        interval_error <= 1'b1;
      end else if (err_clear) begin
        interval_error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cms_axis_trace_receiver.sv
// tb/tb_cms_axis_trace_receiver.sv - scoreboard bench for cms_axis_trace_receiver
module tb_cms_axis_trace_receiver;
  localparam int W     = 1024;
  localparam int OW    = 64;
  localparam int WORDS = W / OW;

  typedef struct {
    logic [OW-1:0] data;
    bit            last;
    int            idx;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tlast_interval = '0;
  logic        err_clear = 1'b0;
  logic [63:0] pkt_pc;
  logic [31:0] pkt_instr;
  logic [31:0] beat_count;
  logic [31:0] frame_count;
  logic        interval_error;

  cms_axis_trace_receiver_if #(.AXI_DATA_WIDTH(W), .OUT_WIDTH(OW)) bus ();

  cms_axis_trace_receiver dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .tlast_interval (tlast_interval),
    .err_clear      (err_clear),
    .pkt_pc         (pkt_pc),
    .pkt_instr      (pkt_instr),
    .beat_count     (beat_count),
    .frame_count    (frame_count),
    .interval_error (interval_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  word_t       q[$];
  logic [31:0] m_beats = '0;
  logic [31:0] m_frames = '0;
  logic [31:0] m_n = '0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  bit          m_err = 1'b0;

  int rmode = 0;
  int rcyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Consumer ready: 0 = always, 1 = random, 2 = repeating 1,0,0,1
  always @(posedge clk) begin
    #1;
    rcyc++;
    case (rmode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
    endcase
  end

  // Monitor: compares DUT outputs with the scoreboard head every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_tready", bus.S_AXIS_tready,
          (q.size() == 0) || (q.size() == 1 && bus.out_ready));
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0].data);
        chk("out_last", bus.out_last, q[0].last);
        chk("out_word_idx", bus.out_word_idx, q[0].idx);
        if (bus.out_ready) void'(q.pop_front());
      end
      chk("beat_count", beat_count, m_beats);
      chk("frame_count", frame_count, m_frames);
      chk("pkt_pc", pkt_pc, m_pc);
      chk("pkt_instr", pkt_instr, m_instr);
      chk("interval_error", interval_error, m_err);
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_beat();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Offers one beat; the expected words and bookkeeping are recorded on the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input bit last, input bit clr);
    bit acc = 1'b0;
    bit vio;
    int waited = 0;
    bus.S_AXIS_tvalid = 1'b1;
    bus.S_AXIS_tdata  = d;
    bus.S_AXIS_tlast  = last;
    err_clear         = clr;
    while (!acc && waited < 300) begin
      @(negedge clk);
      acc = bus.S_AXIS_tready;
      @(posedge clk);
      vio = 1'b0;
      if (acc) begin
        for (int k = 0; k < WORDS; k++) begin
          word_t w;
          w.data = d[k*OW +: OW];
          w.last = last && (k == WORDS - 1);
          w.idx  = k;
          q.push_back(w);
        end
        m_beats = m_beats + 1;
        if (last) m_frames = m_frames + 1;
        m_pc    = d[805 +: 64];
        m_instr = d[933 +: 32];
        if (tlast_interval != 0) begin
          if (last && (m_n + 1 != tlast_interval)) vio = 1'b1;
          if (!last && (m_n + 1 == tlast_interval)) vio = 1'b1;
        end
        m_n = (last || vio) ? 32'd0 : m_n + 1;
      end
      if (vio) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
      waited++;
    end
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    #1;
    bus.S_AXIS_tvalid = 1'b0;
    err_clear         = 1'b0;
  endtask

  task automatic clear_err();
    err_clear = 1'b1;
    @(posedge clk);
    m_err = 1'b0;
    #1;
    err_clear = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    sync();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    bus.S_AXIS_tvalid = 1'b0;
    bus.S_AXIS_tdata  = '0;
    bus.S_AXIS_tlast  = 1'b0;
    bus.out_ready     = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_word_idx", bus.out_word_idx, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_pkt_pc", pkt_pc, 0);
    chk("rst_err", interval_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sync();

    // Counting-pattern beat
    for (int k = 0; k < WORDS; k++) d[k*OW +: OW] = 64'h1000 + k;
    send_beat(d, 1'b0, 1'b0);
    drain();
    chk("t1_beat_count", beat_count, 1);

    // PC / instruction decode
    d = rand_beat();
    d[805 +: 64] = 64'h14;
    d[933 +: 32] = 32'h0000006f;
    send_beat(d, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_pkt_pc", pkt_pc, 64'h14);
    chk("t2_pkt_instr", pkt_instr, 32'h6f);
    sync();
    drain();

    // Back-to-back beats
    send_beat(rand_beat(), 1'b0, 1'b0);
    send_beat(rand_beat(), 1'b1, 1'b0);
    drain();

    // Consumer stalls
    rmode = 2;
    send_beat(rand_beat(), 1'b0, 1'b0);
    drain();
    rmode = 0;

    // Interval check: re-sync frame counter, then tlast pattern 0,0,1,0,1 at interval 3
    send_beat(rand_beat(), 1'b1, 1'b0);
    tlast_interval = 32'd3;
    send_beat(rand_beat(), 1'b0, 1'b0);
    send_beat(rand_beat(), 1'b0, 1'b0);
    send_beat(rand_beat(), 1'b1, 1'b0);
    send_beat(rand_beat(), 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_err_before", interval_error, 0);
    sync();
    send_beat(rand_beat(), 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_err_after", interval_error, 1);
    sync();
    clear_err();
    @(negedge clk);
    chk("t5_err_cleared", interval_error, 0);
    sync();
    send_beat(rand_beat(), 1'b1, 1'b1);
    @(negedge clk);
    chk("t5_set_wins", interval_error, 1);
    sync();
    drain();

    // Randomized traffic
    rmode = 1;
    for (int b = 0; b < 40; b++) begin
      if (b % 10 == 0) tlast_interval = $urandom_range(0, 5);
      send_beat(rand_beat(), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rmode = 0;

    // Asynchronous reset in the middle of a beat
    send_beat(rand_beat(), 1'b0, 1'b0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        seen = bus.out_valid && (bus.out_word_idx == 7);
      end
      chk("t6_reach_idx7", seen, 1);
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    m_beats = '0; m_frames = '0; m_n = '0; m_pc = '0; m_instr = '0; m_err = 1'b0;
    #1;
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_beat_count", beat_count, 0);
    chk("t6_frame_count", frame_count, 0);
    chk("t6_pkt_pc", pkt_pc, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_tready", bus.S_AXIS_tready, 1);
    chk("t6_idle", bus.out_valid, 0);
    sync();
    send_beat(rand_beat(), 1'b1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
